// File: rtl/bus_cycle_controller.sv
// 68030 bus-termination engine: per-device wait count, ready extension and port width drive DSACK/BERR.
// Optional bus-timeout watchdog is built when BUS_TIMEOUT_EN is defined.
module bus_cycle_controller #(
  parameter int NUM_DEVICES    = 8,
  parameter int WAIT_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              as,
  input  logic                              enable,
  input  logic [NUM_DEVICES-1:0]            device_selected,
  input  logic [NUM_DEVICES*WAIT_WIDTH-1:0] wait_cycles,
  input  logic [2*NUM_DEVICES-1:0]          port_width,
  input  logic [NUM_DEVICES-1:0]            ext_wait,
  output logic [1:0]                        n_dsack,
  output logic                              dsack_oe,
  output logic                              n_berr,
  output logic                              busy,
  output logic                              timeout_flag
);

  localparam int IDX_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_BERR = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [WAIT_WIDTH-1:0] wait_arr [NUM_DEVICES];
  logic [1:0]            pw_arr   [NUM_DEVICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_unpack
      assign wait_arr[gi] = wait_cycles[gi*WAIT_WIDTH +: WAIT_WIDTH];
      assign pw_arr[gi]   = port_width[2*gi +: 2];
    end
  endgenerate

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]            pw_q, pw_d;
  logic [1:0]            n_dsack_q, n_dsack_d;
  logic                  n_berr_q, n_berr_d;
  logic                  dsack_oe_q, dsack_oe_d;
  logic                  busy_q, busy_d;
  logic                  timeout_hit;

  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_any;
  logic [WAIT_WIDTH-1:0] sel_wait;
  logic [1:0]            sel_pw;

  // Lowest-numbered select wins when the decoder asserts more than one.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (device_selected[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  assign sel_wait = wait_arr[sel_idx];
  assign sel_pw   = pw_arr[sel_idx];

`ifdef BUS_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_flag_q, timeout_flag_d;

  assign timeout_hit  = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pw_d      = pw_q;
    n_dsack_d = 2'b11;
    n_berr_d  = 1'b1;
`ifdef BUS_TIMEOUT_EN
    timer_d        = timer_q;
    timeout_flag_d = timeout_flag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (as && enable) begin
          idx_d = sel_idx;
          cnt_d = sel_wait;
          pw_d  = sel_pw;
`ifdef BUS_TIMEOUT_EN
          timer_d = '0;
`endif
          // BERR output follows one clock after entry so it lines up with the decode latency.
          state_d = (!sel_any || sel_pw == 2'b11) ? S_BERR : S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef BUS_TIMEOUT_EN
        timer_d = timer_q + 1'b1;
`endif
        if (!as) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!ext_wait[idx_q]) begin
          state_d   = S_ACK;
          n_dsack_d = pw_q;
        end else if (timeout_hit) begin
          state_d  = S_BERR;
          n_berr_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
          timeout_flag_d = 1'b1;
`endif
        end
      end
      S_ACK: begin
        if (as) n_dsack_d = pw_q;
        else    state_d   = S_HOLD;
      end
      S_BERR: begin
        if (as) n_berr_d = 1'b0;
        else    state_d  = S_HOLD;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    dsack_oe_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pw_q       <= 2'b00;
      n_dsack_q  <= 2'b11;
      n_berr_q   <= 1'b1;
      dsack_oe_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      timer_q        <= '0;
      timeout_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pw_q       <= pw_d;
      n_dsack_q  <= n_dsack_d;
      n_berr_q   <= n_berr_d;
      dsack_oe_q <= dsack_oe_d;
      busy_q     <= busy_d;
`ifdef BUS_TIMEOUT_EN
      timer_q        <= timer_d;
      timeout_flag_q <= timeout_flag_d;
`endif
    end
  end

  assign n_dsack  = n_dsack_q;
  assign n_berr   = n_berr_q;
  assign dsack_oe = dsack_oe_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller: directed cases plus randomized cycles against a latency model.
module tb_bus_cycle_controller;
  localparam int N  = 8;
  localparam int WW = 4;

  logic            clock = 1'b0;
  logic            reset, as, enable;
  logic [N-1:0]    device_selected, ext_wait;
  logic [N*WW-1:0] wait_cycles;
  logic [2*N-1:0]  port_width;
  logic [1:0]      n_dsack;
  logic            dsack_oe, n_berr, busy, timeout_flag;

  int n_checks = 0;
  int n_fails  = 0;

  bus_cycle_controller #(.NUM_DEVICES(N), .WAIT_WIDTH(WW), .TIMEOUT_CYCLES(256)) dut (
    .clock(clock), .reset(reset), .as(as), .enable(enable),
    .device_selected(device_selected), .wait_cycles(wait_cycles),
    .port_width(port_width), .ext_wait(ext_wait),
    .n_dsack(n_dsack), .dsack_oe(dsack_oe), .n_berr(n_berr),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] ds, input logic be,
                            input logic oe, input logic bsy);
    check({tag, ".n_dsack"},  32'(n_dsack),  32'(ds));
    check({tag, ".n_berr"},   32'(n_berr),   32'(be));
    check({tag, ".dsack_oe"}, 32'(dsack_oe), 32'(oe));
    check({tag, ".busy"},     32'(busy),     32'(bsy));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int lowest_sel(input logic [N-1:0] sel);
    for (int i = 0; i < N; i++) if (sel[i]) return i;
    return -1;
  endfunction

  // One complete bus cycle. Expected termination edge: E1 for no-select/illegal width,
  // otherwise E(W+1+x_ext). Selects and configuration are scrambled after E0.
  task automatic run_txn(input int t, input logic [N-1:0] sel, input logic [N*WW-1:0] wc,
                         input logic [2*N-1:0] pw, input int x_ext, input int hold);
    int idx, w, lat;
    logic [1:0] p;
    bit err;
    idx = lowest_sel(sel);
    w   = (idx >= 0) ? int'(wc[idx*WW +: WW]) : 0;
    p   = (idx >= 0) ? pw[2*idx +: 2] : 2'b11;
    err = (idx < 0) || (p == 2'b11);
    lat = err ? 1 : w + 1 + x_ext;
    device_selected = sel;
    wait_cycles     = wc;
    port_width      = pw;
    ext_wait        = N'($urandom);
    enable          = 1'b1;
    as              = 1'b1;
    tick();
    check_outs("start", 2'b11, 1'b1, 1'b1, 1'b1);
    for (int j = 1; j <= lat; j++) begin
      device_selected = N'($urandom);
      wait_cycles     = $urandom;
      port_width      = (2*N)'($urandom);
      ext_wait        = N'($urandom);
      if (!err && j > w) ext_wait[idx] = (j <= w + x_ext);
      tick();
      if (j < lat)  check_outs("wait", 2'b11, 1'b1, 1'b1, 1'b1);
      else if (err) check_outs("berr", 2'b11, 1'b0, 1'b1, 1'b1);
      else          check_outs("ack",  p,     1'b1, 1'b1, 1'b1);
    end
    for (int h = 0; h < hold; h++) begin
      ext_wait = N'($urandom);
      tick();
      check_outs("held", err ? 2'b11 : p, err ? 1'b0 : 1'b1, 1'b1, 1'b1);
    end
    as = 1'b0;
    tick();
    check_outs("hold", 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    check_outs("idle", 2'b11, 1'b1, 1'b0, 1'b0);
    check("txn.timeout_flag", 32'(timeout_flag), 32'd0);
    $display("txn %0d: sel=%02h idx=%0d W=%0d pw=%b ext=%0d -> %s at E%0d", t, sel, idx, w, p,
             x_ext, err ? "BERR" : "DSACK", lat);
  endtask

  logic [N*WW-1:0] wc;
  logic [2*N-1:0]  pw;
  logic [N-1:0]    sel;

  initial begin
    reset = 1'b1; as = 1'b0; enable = 1'b0;
    device_selected = '0; wait_cycles = '0; port_width = '0; ext_wait = '0;
    tick();
    check_outs("reset", 2'b11, 1'b1, 1'b0, 1'b0);
    check("reset.timeout_flag", 32'(timeout_flag), 32'd0);
    reset = 1'b0;
    tick();

    // Device 3, W=2, 16-bit port: DSACK=01 after E3.
    wc = $urandom; wc[3*WW +: WW] = 4'd2;
    pw = 16'h0000; pw[7:6] = 2'b01;
    run_txn(0, 8'b0000_1000, wc, pw, 0, 2);

    // Devices 2 and 5 selected: channel 2 wins, 8-bit port after E1.
    wc = $urandom; wc[2*WW +: WW] = 4'd0;
    pw = 16'hFFFF; pw[5:4] = 2'b10;
    run_txn(1, 8'b0010_0100, wc, pw, 0, 1);

    // No select: BERR.
    run_txn(2, 8'h00, 32'h0, 16'h0, 0, 3);

    // Device 0, W=1, ext_wait for 5 clocks: DSACK after E7.
    wc = $urandom; wc[WW-1:0] = 4'd1;
    run_txn(3, 8'b0000_0001, wc, 16'h0000, 5, 0);

    // Illegal port width on selected device: BERR after E1.
    pw = 16'h0000; pw[13:12] = 2'b11;
    run_txn(4, 8'b0100_0000, 32'h0, pw, 0, 1);

    // Without enable no cycle is accepted.
    device_selected = 8'h01; wait_cycles = '0; port_width = '0; ext_wait = '0;
    enable = 1'b0; as = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs("noenable", 2'b11, 1'b1, 1'b0, 1'b0);
    end
    as = 1'b0;
    tick();
    $display("txn 5: enable low, no cycle accepted");

    // Abort in WAIT with cnt=3: back to IDLE at that edge, nothing issued.
    device_selected = 8'h02; wait_cycles = '0; wait_cycles[WW +: WW] = 4'd5;
    port_width = '0; ext_wait = '0; enable = 1'b1; as = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs("abort.wait", 2'b11, 1'b1, 1'b1, 1'b1);
    end
    as = 1'b0;
    tick();
    check_outs("abort.idle", 2'b11, 1'b1, 1'b0, 1'b0);
    $display("txn 6: abort in WAIT at cnt=3");
    wc = '0; wc[WW +: WW] = 4'd1;
    run_txn(7, 8'h02, wc, 16'h0008, 0, 0);

    // Reset while in ACK.
    device_selected = 8'h10; wait_cycles = '0; port_width = 16'h0100;
    ext_wait = '0; as = 1'b1;
    tick();
    tick();
    check_outs("rstack.ack", 2'b01, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    check_outs("rstack.reset", 2'b11, 1'b1, 1'b0, 1'b0);
    reset = 1'b0; as = 1'b0;
    tick();
    check_outs("rstack.after", 2'b11, 1'b1, 1'b0, 1'b0);
    $display("txn 8: reset during ACK");

    for (int t = 9; t < 49; t++) begin
      sel = ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom);
      run_txn(t, sel, $urandom, (2*N)'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // ext_wait stuck high on device 0.
    device_selected = 8'h01; wait_cycles = '0; wait_cycles[WW-1:0] = 4'd1;
    port_width = '0; ext_wait = 8'h01; as = 1'b1;
`ifdef BUS_TIMEOUT_EN
    for (int k = 0; k < 256; k++) tick();
    check_outs("to.before", 2'b11, 1'b1, 1'b1, 1'b1);
    check("to.flag_before", 32'(timeout_flag), 32'd0);
    tick();
    check_outs("to.berr", 2'b11, 1'b0, 1'b1, 1'b1);
    check("to.flag", 32'(timeout_flag), 32'd1);
    as = 1'b0;
    tick();
    check_outs("to.hold", 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    check_outs("to.idle", 2'b11, 1'b1, 1'b0, 1'b0);
    check("to.flag_sticky", 32'(timeout_flag), 32'd1);
    $display("txn 49: stuck ext_wait, watchdog BERR at E256");
`else
    for (int k = 0; k < 1001; k++) begin
      tick();
      check_outs("stuck.wait", 2'b11, 1'b1, 1'b1, 1'b1);
    end
    check("stuck.flag", 32'(timeout_flag), 32'd0);
    as = 1'b0;
    tick();
    check_outs("stuck.idle", 2'b11, 1'b1, 1'b0, 1'b0);
    $display("txn 49: stuck ext_wait, no BERR after 1000 clocks");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
